// File: rtl/if_prefetch_unit_if.sv
// if_prefetch_unit_if: redirect, fetch-bus and ID-handshake signals of the prefetch unit.
interface if_prefetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              redir_jmp;
    logic [ADDR_W-1:0] redir_addr;
    logic              redir_sys;
    logic              redir_eret;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_ir;
    logic [ADDR_W-1:0] out_pc_plus4;

    modport master (
        input  redir_jmp, redir_addr, redir_sys, redir_eret, epc,
        output m_araddr, m_arvalid,
        input  m_arready, m_rdata, m_rvalid,
        output out_valid, out_pc, out_ir, out_pc_plus4,
        input  out_ready
    );

    modport slave (
        output redir_jmp, redir_addr, redir_sys, redir_eret, epc,
        input  m_araddr, m_arvalid,
        output m_arready, m_rdata, m_rvalid,
        input  out_valid, out_pc, out_ir, out_pc_plus4,
        output out_ready
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction fetch with a credit-limited prefetch queue and redirect flush.
module if_prefetch_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [ADDR_W-1:0] SYSCALL_PC = 'h3000
) (
    input logic                  clk,
    input logic                  rst_n,
    if_prefetch_unit_if.master   io_pf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {S_RESET, S_RUN, S_DRAIN} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [CW-1:0]     r_count, r_outstanding, r_drop;
    logic [CW-1:0]     w_outstanding_next, w_drop_next;
    logic [AW-1:0]     r_wptr, r_rptr, r_tw, r_tr;
    logic [ADDR_W-1:0] r_tag     [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc [DEPTH];
    logic [DATA_W-1:0] r_fifo_ir [DEPTH];
    logic              w_redir, w_issue, w_keep, w_pop;
    logic [ADDR_W-1:0] w_new_pc;

    assign w_redir  = io_pf.redir_jmp | io_pf.redir_sys | io_pf.redir_eret;
    assign w_new_pc = io_pf.redir_jmp ? io_pf.redir_addr :
                      io_pf.redir_sys ? SYSCALL_PC : io_pf.epc;

    // Credits cover both buffered and in-flight fetches, so the FIFO can never overflow.
    assign io_pf.m_arvalid = (r_state != S_RESET) && !w_redir &&
                             (({1'b0, r_count} + {1'b0, r_outstanding}) < SW'(DEPTH));
    assign io_pf.m_araddr  = r_pc;
    assign w_issue = io_pf.m_arvalid && io_pf.m_arready;
    assign w_keep  = io_pf.m_rvalid && (r_drop == '0) && !w_redir;
    assign w_pop   = io_pf.out_valid && io_pf.out_ready;

    assign io_pf.out_valid    = r_count != '0;
    assign io_pf.out_pc       = r_fifo_pc[r_rptr];
    assign io_pf.out_ir       = r_fifo_ir[r_rptr];
    assign io_pf.out_pc_plus4 = r_fifo_pc[r_rptr] + ADDR_W'(4);

    always_comb begin
        w_outstanding_next = r_outstanding + CW'(w_issue) - CW'(io_pf.m_rvalid);
        w_drop_next        = w_redir ? w_outstanding_next :
                             (io_pf.m_rvalid && r_drop != '0) ? r_drop - CW'(1) : r_drop;
        w_state_next       = (r_state == S_RESET) ? S_RUN :
                             (w_drop_next != '0) ? S_DRAIN : S_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_RESET;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_tw          <= '0;
            r_tr          <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            r_drop        <= w_drop_next;
            if (w_redir) begin
                r_pc    <= w_new_pc;
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_tw    <= '0;
                r_tr    <= '0;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + ADDR_W'(4);
                    r_tw <= r_tw + AW'(1);
                end
                if (w_keep) begin
                    r_tr   <= r_tr + AW'(1);
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) r_rptr <= r_rptr + AW'(1);
                r_count <= r_count + CW'(w_keep) - CW'(w_pop);
            end
        end
    end

    // Tag queue holds only post-redirect request PCs; stale responses never touch it.
    always_ff @(posedge clk) begin
        if (w_issue) r_tag[r_tw] <= r_pc;
        if (w_keep) begin
            r_fifo_pc[r_wptr] <= r_tag[r_tr];
            r_fifo_ir[r_wptr] <= io_pf.m_rdata;
        end
        if (rst_n && w_keep) assert (r_count != CW'(DEPTH));
    end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: directed scoreboard bench with an in-order memory model for if_prefetch_unit.
module tb_if_prefetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_prefetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    if_prefetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4),
        .RESET_PC(32'h0000_0000), .SYSCALL_PC(32'h0000_3000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_pf(bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pend[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          pops = 0;
    int          accepts = 0;
    int          mem_used = 0;
    int          mem_grant = 0;
    bit          mem_free = 1'b1;
    int          cyc, lat, a0;

    function automatic logic [31:0] ir_of(logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // In-order memory: one response per cycle, one cycle after acceptance, gated by free/grant.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            bus.m_rvalid = 1'b0;
        end else begin
            bus.m_rvalid = 1'b0;
            if (pend.size() > 0 && (mem_free || mem_used < mem_grant)) begin
                bus.m_rvalid = 1'b1;
                bus.m_rdata  = ir_of(pend.pop_front());
                mem_used++;
            end
            if (bus.m_arvalid && bus.m_arready) begin
                pend.push_back(bus.m_araddr);
                accepts++;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_exp(logic [31:0] pc, logic [31:0] pc4);
        sb.push_back('{pc, ir_of(pc), pc4});
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid === 1'b1 && bus.out_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_unexpected: got pc %h ir %h, want no output", bus.out_pc, bus.out_ir);
                end else begin
                    e = sb.pop_front();
                    check("out_pc", bus.out_pc, e.pc);
                    check("out_ir", bus.out_ir, e.ir);
                    check("out_pc_plus4", bus.out_pc_plus4, e.pc4);
                end
            end
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic consume(int n, output int c);
        int tgt = pops + n;
        bus.out_ready = 1'b1;
        c = 0;
        while (pops < tgt && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        bus.out_ready = 1'b0;
        check("consume_done", pops, tgt);
    endtask

    task automatic do_reset(bit free, bit rdy);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.redir_jmp = 1'b0;
        bus.redir_sys = 1'b0;
        bus.redir_eret = 1'b0;
        bus.out_ready = rdy;
        mem_free = free;
        tick(2);
        check("rst_arvalid", bus.m_arvalid, 0);
        check("rst_out_valid", bus.out_valid, 0);
        sb.delete();
        mem_grant = mem_used;
        a0 = accepts;
        rst_n = 1'b1;
        #1;
        check("reset_state_no_issue", bus.m_arvalid, 0);
    endtask

    initial begin
        bus.redir_jmp = 1'b0;
        bus.redir_sys = 1'b0;
        bus.redir_eret = 1'b0;
        bus.redir_addr = '0;
        bus.epc = '0;
        bus.m_arready = 1'b1;
        bus.out_ready = 1'b0;
        fork
            monitor();
        join_none

        // 1: reset latency and back-to-back stream
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4), 32'(i * 4 + 4));
        tick(1);
        check("t1_first_arvalid", bus.m_arvalid, 1);
        check("t1_first_araddr", bus.m_araddr, 32'h0);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick(1);
            lat++;
        end
        check("t1_out_latency", lat, 3);
        consume(4, cyc);
        check("t1_back_to_back", cyc, 4);
        check("t1_sb_empty", sb.size(), 0);

        // 2: credit limit with ID stalled
        do_reset(1'b1, 1'b0);
        tick(12);
        check("t2_accepts_full", accepts - a0, 4);
        check("t2_arvalid_stall", bus.m_arvalid, 0);
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4), 32'(i * 4 + 4));
        consume(1, cyc);
        tick(5);
        check("t2_accepts_after_pop1", accepts - a0, 5);
        consume(3, cyc);
        tick(5);
        check("t2_accepts_after_pop4", accepts - a0, 8);
        check("t2_arvalid_restall", bus.m_arvalid, 0);
        check("t2_sb_empty", sb.size(), 0);

        // 3: redirect with 3 in flight and 1 queued
        do_reset(1'b0, 1'b0);
        mem_grant = mem_used + 1;
        tick(12);
        check("t3_accepts", accepts - a0, 4);
        check("t3_queued_one", bus.out_valid, 1);
        bus.redir_jmp = 1'b1;
        bus.redir_addr = 32'h100;
        #1;
        check("t3_no_issue_on_redir", bus.m_arvalid, 0);
        tick(1);
        bus.redir_jmp = 1'b0;
        mem_free = 1'b1;
        #1;
        check("t3_fifo_cleared", bus.out_valid, 0);
        check("t3_issue_new_pc", bus.m_araddr, 32'h100);
        push_exp(32'h100, 32'h104);
        push_exp(32'h104, 32'h108);
        consume(2, cyc);
        check("t3_sb_empty", sb.size(), 0);

        // 4: jmp beats sys, same-cycle response dropped; then sys alone
        do_reset(1'b0, 1'b0);
        tick(12);
        check("t4_none_returned", bus.out_valid, 0);
        bus.redir_jmp = 1'b1;
        bus.redir_sys = 1'b1;
        bus.redir_addr = 32'h200;
        mem_grant = mem_used + 1;
        tick(1);
        bus.redir_jmp = 1'b0;
        bus.redir_sys = 1'b0;
        mem_free = 1'b1;
        #1;
        check("t4_resp_dropped", bus.out_valid, 0);
        push_exp(32'h200, 32'h204);
        consume(1, cyc);
        bus.redir_sys = 1'b1;
        tick(1);
        bus.redir_sys = 1'b0;
        push_exp(32'h3000, 32'h3004);
        consume(1, cyc);
        check("t4_sb_empty", sb.size(), 0);

        // 5: eret during a pop
        do_reset(1'b1, 1'b0);
        tick(12);
        push_exp(32'h0, 32'h4);
        push_exp(32'h80, 32'h84);
        bus.out_ready = 1'b1;
        bus.redir_eret = 1'b1;
        bus.epc = 32'h80;
        tick(1);
        bus.redir_eret = 1'b0;
        #1;
        check("t5_fifo_cleared", bus.out_valid, 0);
        check("t5_popped_before", pops >= 1, 1);
        consume(1, cyc);
        check("t5_sb_empty", sb.size(), 0);

        // 6: PC wrap
        do_reset(1'b1, 1'b0);
        tick(12);
        bus.redir_jmp = 1'b1;
        bus.redir_addr = 32'hFFFF_FFFC;
        tick(1);
        bus.redir_jmp = 1'b0;
        #1;
        check("t6_araddr_top", bus.m_araddr, 32'hFFFF_FFFC);
        tick(1);
        check("t6_araddr_wrap", bus.m_araddr, 32'h0000_0000);
        push_exp(32'hFFFF_FFFC, 32'h0000_0000);
        push_exp(32'h0000_0000, 32'h0000_0004);
        consume(2, cyc);
        check("t6_sb_empty", sb.size(), 0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1);
    end
endmodule
